// File: rtl/boc_code_gen.sv
// boc_code_gen
//   Local replica generator for the B1 tracking channel. Produces one local
//   BOC(1,1) sample per clock together with code-period markers for the
//   correlation accumulator. The code is the 2046-chip truncated B1 Gold code
//   (G1 and G2 11-stage LFSRs, G2 phase chosen by a tap pair). The chip rate
//   comes from a code NCO, and the subcarrier is the NCO phase MSB.
//
// Ports
//   rx_clk       sample clock
//   rx_rst       synchronous active-low reset
//   rx_start     pulse: reload LFSRs, clear NCO and chip count, enter RUN
//   rx_stop      pulse: return to IDLE (rx_start has priority)
//   rx_code_fcw  code NCO frequency word; a chip advances on phase carry-out
//   rx_g2_tap_a  first G2 output tap, stage 1..11 (other values contribute 0)
//   rx_g2_tap_b  second G2 output tap, stage 1..11
//   tx_valid     high while outputs carry live samples
//   tx_loc_boc   local BOC sample, 1 = +1, 0 = -1
//   tx_prn_sop   first sample of a code period
//   tx_prn_eop   last sample of a code period
//   tx_chip_idx  chip index of the emitted sample, 0..CODE_LEN-1
module boc_code_gen #(
  parameter int unsigned NCO_WIDTH = 32,
  parameter int unsigned CODE_LEN  = 2046,
  parameter logic [10:0] G1_INIT   = 11'b01010101010,
  parameter logic [10:0] G2_INIT   = 11'b01010101010
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_start,
  input  logic                 rx_stop,
  input  logic [NCO_WIDTH-1:0] rx_code_fcw,
  input  logic [3:0]           rx_g2_tap_a,
  input  logic [3:0]           rx_g2_tap_b,
  output logic                 tx_valid,
  output logic                 tx_loc_boc,
  output logic                 tx_prn_sop,
  output logic                 tx_prn_eop,
  output logic [10:0]          tx_chip_idx
);

  localparam logic [10:0] LAST_IDX = 11'(CODE_LEN - 1);
  // Feedback stage masks, stage1 in bit0.
  localparam logic [10:0] G1_FB_MASK = 11'b11111000001; // stages 1,7,8,9,10,11
  localparam logic [10:0] G2_FB_MASK = 11'b10110011111; // stages 1,2,3,4,5,8,9,11

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state, state_nxt;
  logic [NCO_WIDTH-1:0] phase, phase_nxt;
  logic [10:0]          chip_idx, chip_idx_nxt;
  logic [10:0]          g1, g1_nxt;
  logic [10:0]          g2, g2_nxt;
  logic                 new_chip, new_chip_nxt;

  // Working values for the current step (register contents or load values).
  logic [NCO_WIDTH-1:0] cur_phase;
  logic [10:0]          cur_idx;
  logic [10:0]          cur_g1;
  logic [10:0]          cur_g2;
  logic                 cur_new;
  logic                 run_step;
  logic [NCO_WIDTH:0]   phase_sum;
  logic                 carry;
  logic                 chip;

  logic                 valid_nxt;
  logic                 boc_nxt;
  logic                 sop_nxt;
  logic                 eop_nxt;
  logic [10:0]          idx_out_nxt;

  function automatic logic tap_bit(input logic [10:0] g, input logic [3:0] tap);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (tap == 4'(i + 1)) b = g[i];
    end
    return b;
  endfunction

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      state       <= IDLE;
      phase       <= '0;
      chip_idx    <= '0;
      g1          <= G1_INIT;
      g2          <= G2_INIT;
      new_chip    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_loc_boc  <= 1'b0;
      tx_prn_sop  <= 1'b0;
      tx_prn_eop  <= 1'b0;
      tx_chip_idx <= '0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      chip_idx    <= chip_idx_nxt;
      g1          <= g1_nxt;
      g2          <= g2_nxt;
      new_chip    <= new_chip_nxt;
      tx_valid    <= valid_nxt;
      tx_loc_boc  <= boc_nxt;
      tx_prn_sop  <= sop_nxt;
      tx_prn_eop  <= eop_nxt;
      tx_chip_idx <= idx_out_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    chip_idx_nxt = chip_idx;
    g1_nxt       = g1;
    g2_nxt       = g2;
    new_chip_nxt = new_chip;
    valid_nxt    = 1'b0;
    boc_nxt      = 1'b0;
    sop_nxt      = 1'b0;
    eop_nxt      = 1'b0;
    idx_out_nxt  = '0;

    // A start folds the load into the same edge as the first step, so the
    // first live sample (chip 0, phase 0) appears one cycle after the start
    // edge and a restart from RUN leaves no gap.
    cur_phase = rx_start ? '0      : phase;
    cur_idx   = rx_start ? '0      : chip_idx;
    cur_g1    = rx_start ? G1_INIT : g1;
    cur_g2    = rx_start ? G2_INIT : g2;
    cur_new   = rx_start ? 1'b1    : new_chip;

    run_step  = rx_start || ((state == RUN) && !rx_stop);

    phase_sum = {1'b0, cur_phase} + {1'b0, rx_code_fcw};
    carry     = phase_sum[NCO_WIDTH];
    chip      = cur_g1[10] ^ tap_bit(cur_g2, rx_g2_tap_a) ^ tap_bit(cur_g2, rx_g2_tap_b);

    if (rx_start) begin
      state_nxt = RUN;
    end else if (rx_stop) begin
      state_nxt = IDLE;
    end

    if (run_step) begin
      valid_nxt    = 1'b1;
      boc_nxt      = chip ^ cur_phase[NCO_WIDTH-1];
      // cur_new marks a chip not yet emitted, so sop fires once per period
      // even when the NCO is frozen.
      sop_nxt      = cur_new && (cur_idx == '0);
      eop_nxt      = carry && (cur_idx == LAST_IDX);
      idx_out_nxt  = cur_idx;

      phase_nxt    = phase_sum[NCO_WIDTH-1:0];
      new_chip_nxt = carry;
      chip_idx_nxt = cur_idx;
      g1_nxt       = cur_g1;
      g2_nxt       = cur_g2;

      if (carry) begin
        if (cur_idx == LAST_IDX) begin
          // Reload truncates the 2047-chip sequence to CODE_LEN chips.
          chip_idx_nxt = '0;
          g1_nxt       = G1_INIT;
          g2_nxt       = G2_INIT;
        end else begin
          chip_idx_nxt = cur_idx + 11'd1;
          g1_nxt       = {cur_g1[9:0], ^(cur_g1 & G1_FB_MASK)};
          g2_nxt       = {cur_g2[9:0], ^(cur_g2 & G2_FB_MASK)};
        end
      end
    end
  end

endmodule

// File: tb/tb_boc_code_gen.sv
// tb_boc_code_gen
//   Directed self-checking bench for boc_code_gen. Expected code chips come
//   from a stage-array Gold code model built at time zero; the first chips of
//   several tap pairs are checked against hand-computed sample patterns.
module tb_boc_code_gen;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_start;
  logic        rx_stop;
  logic [31:0] rx_code_fcw;
  logic [3:0]  rx_g2_tap_a;
  logic [3:0]  rx_g2_tap_b;
  logic        tx_valid;
  logic        tx_loc_boc;
  logic        tx_prn_sop;
  logic        tx_prn_eop;
  logic [10:0] tx_chip_idx;

  int n_cmp = 0;
  int n_err = 0;

  bit code [0:2045];

  always #5 rx_clk = ~rx_clk;

  boc_code_gen #(
    .NCO_WIDTH (32),
    .CODE_LEN  (2046),
    .G1_INIT   (11'b01010101010),
    .G2_INIT   (11'b01010101010)
  ) dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .rx_start    (rx_start),
    .rx_stop     (rx_stop),
    .rx_code_fcw (rx_code_fcw),
    .rx_g2_tap_a (rx_g2_tap_a),
    .rx_g2_tap_b (rx_g2_tap_b),
    .tx_valid    (tx_valid),
    .tx_loc_boc  (tx_loc_boc),
    .tx_prn_sop  (tx_prn_sop),
    .tx_prn_eop  (tx_prn_eop),
    .tx_chip_idx (tx_chip_idx)
  );

  task automatic tick;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view: {valid, boc, sop, eop, chip_idx[10:0]}
  function automatic logic [31:0] outs();
    return {17'b0, tx_valid, tx_loc_boc, tx_prn_sop, tx_prn_eop, tx_chip_idx};
  endfunction

  task automatic chk_idle(input string tag);
    chk(tag, outs(), 32'd0);
  endtask

  // Checks n samples of a fresh run (taps 1,3) with spc samples per chip.
  // Any pulse set by the caller is dropped after the first edge.
  task automatic check_run(input int spc, input int n, input string tag);
    int ci;
    int per;
    logic [31:0] exp;
    per = spc * 2046;
    for (int k = 0; k < n; k++) begin
      tick;
      rx_start = 1'b0;
      rx_stop  = 1'b0;
      ci  = (k / spc) % 2046;
      exp = {17'b0, 1'b1, code[ci] ^ ((k % spc) >= (spc / 2)),
             (k % per) == 0, (k % per) == (per - 1), 11'(ci)};
      chk($sformatf("%s[%0d]", tag, k), outs(), exp);
    end
  endtask

  // Eight BOC samples at fcw=0x8000_0000; vec bit i is sample i.
  task automatic hand_run(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] vec, input string tag);
    rx_g2_tap_a = a;
    rx_g2_tap_b = b;
    rx_code_fcw = 32'h8000_0000;
    rx_start    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      rx_start = 1'b0;
      chk($sformatf("%s[%0d]", tag, i), {31'b0, tx_loc_boc}, {31'b0, vec[i]});
    end
  endtask

  initial begin
    bit s1 [1:11];
    bit s2 [1:11];
    bit f1;
    bit f2;

    // Gold code reference for taps (1,3): stages indexed by number.
    for (int i = 1; i <= 11; i++) begin
      s1[i] = (i % 2) == 0;
      s2[i] = (i % 2) == 0;
    end
    for (int c = 0; c < 2046; c++) begin
      code[c] = s1[11] ^ s2[1] ^ s2[3];
      f1 = s1[1] ^ s1[7] ^ s1[8] ^ s1[9] ^ s1[10] ^ s1[11];
      f2 = s2[1] ^ s2[2] ^ s2[3] ^ s2[4] ^ s2[5] ^ s2[8] ^ s2[9] ^ s2[11];
      for (int i = 11; i >= 2; i--) begin
        s1[i] = s1[i-1];
        s2[i] = s2[i-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end

    rx_rst      = 1'b0;
    rx_start    = 1'b0;
    rx_stop     = 1'b0;
    rx_code_fcw = 32'h0;
    rx_g2_tap_a = 4'd1;
    rx_g2_tap_b = 4'd3;

    // Reset held, then released with no start.
    repeat (3) tick;
    chk_idle("reset");
    rx_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk_idle($sformatf("idle_no_start[%0d]", i));
    end

    // Hand-derived first chips: (1,3)=0,1,1,0; (5,5) and (0,12) leave G1 only
    // = 0,1,0,1; (1,13) keeps G1^G2[1] = 0,0,1,1.
    hand_run(4'd1,  4'd3,  8'h96, "hand_1_3");
    hand_run(4'd5,  4'd5,  8'h66, "hand_5_5");
    hand_run(4'd0,  4'd12, 8'h66, "hand_0_12");
    hand_run(4'd1,  4'd13, 8'h5A, "hand_1_13");
    rx_g2_tap_a = 4'd1;
    rx_g2_tap_b = 4'd3;

    // Ten periods at 2 samples per chip.
    rx_code_fcw = 32'h8000_0000;
    rx_start    = 1'b1;
    check_run(2, 10 * 4092, "run2");

    // Four samples per chip, two periods plus wrap.
    rx_code_fcw = 32'h4000_0000;
    rx_start    = 1'b1;
    check_run(4, 2 * 8184 + 4, "run4");

    // Frozen NCO: sop once, chip 0 forever, no eop.
    rx_code_fcw = 32'h0;
    rx_start    = 1'b1;
    tick;
    rx_start = 1'b0;
    chk("fcw0_first", outs(), {17'b0, 1'b1, code[0], 1'b1, 1'b0, 11'd0});
    for (int i = 0; i < 20; i++) begin
      tick;
      chk($sformatf("fcw0_hold[%0d]", i), outs(), {17'b0, 1'b1, code[0], 1'b0, 1'b0, 11'd0});
    end

    // Restart mid-period at chip 700.
    rx_code_fcw = 32'h8000_0000;
    rx_start    = 1'b1;
    check_run(2, 1401, "pre_restart");
    rx_start = 1'b1;
    check_run(2, 4100, "restart");

    // Stop at chip 100, then simultaneous start/stop from IDLE and from RUN.
    rx_start = 1'b1;
    check_run(2, 201, "pre_stop");
    rx_stop = 1'b1;
    tick;
    rx_stop = 1'b0;
    chk_idle("stop");
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle($sformatf("stopped[%0d]", i));
    end
    rx_start = 1'b1;
    rx_stop  = 1'b1;
    check_run(2, 10, "both_idle");
    rx_start = 1'b1;
    rx_stop  = 1'b1;
    check_run(2, 10, "both_run");

    // Reset at chip 1500, asserted together with a start pulse.
    rx_start = 1'b1;
    check_run(2, 3001, "pre_rst");
    rx_rst   = 1'b0;
    rx_start = 1'b1;
    tick;
    rx_start = 1'b0;
    chk_idle("rst_mid");
    tick;
    tick;
    chk_idle("rst_held");
    rx_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk_idle($sformatf("post_rst_idle[%0d]", i));
    end
    rx_start = 1'b1;
    check_run(2, 4100, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
